lfsr_checker: RTL and testbench

- Receive-side companion to the team's XNOR-feedback LFSR pattern generator. Consumes the parallel NUM_BITS-wide words the generator emits, one per valid cycle.
- Self-synchronises by predicting each next word from the feedback polynomial, declares lock, then counts mismatches.
- Used on loopback and link-test paths to verify pseudo-random test patterns end to end.

---
 rtl/lfsr_checker_pkg.sv | 59 +++++
 rtl/lfsr_next_word.sv | 18 +
 rtl/lfsr_checker.sv | 187 ++++++++++++++++++
 tb/tb_lfsr_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the LFSR pattern checker: FSM state type and the
// XNOR tap table used by both the pattern generator and the checker.
package lfsr_checker_pkg;

  // Checker state: searching for the sequence, or tracking it.
  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Counter widths sized for the largest legal LOCK_COUNT/LOSS_COUNT (15).
  // The match counter has to reach LOCK_COUNT+1 (seed plus predictions).
  localparam int MATCH_CNT_BITS = 5;
  localparam int MISS_CNT_BITS  = 4;

  // XNOR feedback tap mask for an n-bit maximal-length LFSR.
  // Bit (t-1) is set for tap t of the classic 1-indexed tap list.
  // Every entry has two or four taps, so a chained XNOR of the tapped bits
  // equals the inverted parity of (word & mask).
  function automatic logic [31:0] tap_mask(input int num_bits);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    case (num_bits)
      3:       mask = 32'h0000_0006;  // 3,2
      4:       mask = 32'h0000_000C;  // 4,3
      5:       mask = 32'h0000_0014;  // 5,3
      6:       mask = 32'h0000_0030;  // 6,5
      7:       mask = 32'h0000_0060;  // 7,6
      8:       mask = 32'h0000_00B8;  // 8,6,5,4
      9:       mask = 32'h0000_0110;  // 9,5
      10:      mask = 32'h0000_0240;  // 10,7
      11:      mask = 32'h0000_0500;  // 11,9
      12:      mask = 32'h0000_0829;  // 12,6,4,1
      13:      mask = 32'h0000_100D;  // 13,4,3,1
      14:      mask = 32'h0000_2015;  // 14,5,3,1
      15:      mask = 32'h0000_6000;  // 15,14
      16:      mask = 32'h0000_D008;  // 16,15,13,4
      17:      mask = 32'h0001_2000;  // 17,14
      18:      mask = 32'h0002_0400;  // 18,11
      19:      mask = 32'h0004_0023;  // 19,6,2,1
      20:      mask = 32'h0009_0000;  // 20,17
      21:      mask = 32'h0014_0000;  // 21,19
      22:      mask = 32'h0030_0000;  // 22,21
      23:      mask = 32'h0042_0000;  // 23,18
      24:      mask = 32'h00E1_0000;  // 24,23,22,17
      25:      mask = 32'h0120_0000;  // 25,22
      26:      mask = 32'h0200_0023;  // 26,6,2,1
      27:      mask = 32'h0400_0013;  // 27,5,2,1
      28:      mask = 32'h0900_0000;  // 28,25
      29:      mask = 32'h1400_0000;  // 29,27
      30:      mask = 32'h2000_0029;  // 30,6,4,1
      31:      mask = 32'h4800_0000;  // 31,28
      32:      mask = 32'h8020_0003;  // 32,22,2,1
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_next_word.sv
// Combinational next-state of the XNOR LFSR: shift left by one and insert
// the XNOR of the tapped bits at bit 0, exactly as the generator does.
module lfsr_next_word
  import lfsr_checker_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] i_word,
  output logic [NUM_BITS-1:0] o_next
);

  localparam logic [31:0]         TAP_MASK = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS     = TAP_MASK[NUM_BITS-1:0];

  // Feedback bit is the XNOR of the tapped bits of the current word.
  assign o_next = {i_word[NUM_BITS-2:0], ~^(i_word & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the XNOR LFSR pattern generator. Hunts for the
// sequence by predicting each word from the previous one, locks after a run
// of correct predictions, then free-runs its own prediction and counts
// mismatching words. Also flags the all-ones lockup word and marks each
// full sequence period seen while locked.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clr_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [CNT_BITS-1:0] o_Err_Count,
  output logic                o_Lockup,
  output logic                o_Period_Done
);

  // Match target: the seed word plus LOCK_COUNT correct predictions.
  localparam logic [MATCH_CNT_BITS-1:0] LOCK_TARGET = MATCH_CNT_BITS'(LOCK_COUNT + 1);
  localparam logic [MISS_CNT_BITS-1:0]  LOSS_TARGET = MISS_CNT_BITS'(LOSS_COUNT);
  // Last period counter value before wrap: 2^NUM_BITS-2.
  localparam logic [NUM_BITS-1:0]       PERIOD_LAST = {{(NUM_BITS-1){1'b1}}, 1'b0};
  localparam logic [NUM_BITS-1:0]       PERIOD_ONE  = {{(NUM_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_BITS-1:0]       ALL_ONES    = {NUM_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0]       CNT_ONE     = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0]       CNT_MAX     = {CNT_BITS{1'b1}};

  state_e                    state_q,       state_d;
  logic [NUM_BITS-1:0]       pred_q,        pred_d;
  logic [MATCH_CNT_BITS-1:0] match_cnt_q,   match_cnt_d;
  logic [MISS_CNT_BITS-1:0]  miss_cnt_q,    miss_cnt_d;
  logic [NUM_BITS-1:0]       period_cnt_q,  period_cnt_d;
  logic                      locked_q,      locked_d;
  logic                      error_q,       error_d;
  logic [CNT_BITS-1:0]       err_count_q,   err_count_d;
  logic                      lockup_q,      lockup_d;
  logic                      period_done_q, period_done_d;

  logic                      accept;
  logic                      pred_hit;
  logic [NUM_BITS-1:0]       data_next;
  logic [NUM_BITS-1:0]       pred_next;
  logic [MATCH_CNT_BITS-1:0] hunt_match_cnt;
  logic [MISS_CNT_BITS-1:0]  miss_inc;

  // Data-path successor: used while hunting, where the prediction
  // re-seeds from whatever arrived.
  lfsr_next_word #(
    .NUM_BITS (NUM_BITS)
  ) u_next_data (
    .i_word (i_Data),
    .o_next (data_next)
  );

  // Prediction-path successor: used while locked, so a corrupted word
  // does not disturb the expected sequence.
  lfsr_next_word #(
    .NUM_BITS (NUM_BITS)
  ) u_next_pred (
    .i_word (pred_q),
    .o_next (pred_next)
  );

  assign accept   = i_Enable & i_Data_DV;
  assign pred_hit = (i_Data == pred_q);

  // Next-state for the FSM, counters and all registered outputs.
  always_comb begin
    state_d        = state_q;
    pred_d         = pred_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    period_cnt_d   = period_cnt_q;
    err_count_d    = err_count_q;
    lockup_d       = lockup_q;
    error_d        = 1'b0;
    period_done_d  = 1'b0;
    hunt_match_cnt = MATCH_CNT_BITS'(1);
    miss_inc       = miss_cnt_q + MISS_CNT_BITS'(1);

    if (accept) begin
      if (i_Data == ALL_ONES) begin
        lockup_d = 1'b1;
      end

      case (state_q)
        ST_HUNT: begin
          // A hit only extends a run that already has a seed word.
          if (pred_hit && (match_cnt_q != '0)) begin
            hunt_match_cnt = match_cnt_q + MATCH_CNT_BITS'(1);
          end
          match_cnt_d = hunt_match_cnt;
          pred_d      = data_next;
          if (hunt_match_cnt == LOCK_TARGET) begin
            state_d      = ST_LOCKED;
            period_cnt_d = '0;
            miss_cnt_d   = '0;
          end
        end

        ST_LOCKED: begin
          pred_d = pred_next;

          if (period_cnt_q == PERIOD_LAST) begin
            period_cnt_d  = '0;
            period_done_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt_q + PERIOD_ONE;
          end

          if (pred_hit) begin
            miss_cnt_d = '0;
          end else begin
            error_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end
            if (miss_inc == LOSS_TARGET) begin
              // Too many misses in a row: drop lock and hunt from scratch.
              state_d     = ST_HUNT;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    // Clear takes effect regardless of enable and overrides a same-cycle
    // error increment or lockup detection.
    if (i_Clr_Count) begin
      err_count_d = '0;
      lockup_d    = 1'b0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // All state and outputs, asynchronously reset to the hunting idle state.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= ST_HUNT;
      pred_q        <= '0;
      match_cnt_q   <= '0;
      miss_cnt_q    <= '0;
      period_cnt_q  <= '0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      err_count_q   <= '0;
      lockup_q      <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pred_q        <= pred_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      period_cnt_q  <= period_cnt_d;
      locked_q      <= locked_d;
      error_q       <= error_d;
      err_count_q   <= err_count_d;
      lockup_q      <= lockup_d;
      period_done_q <= period_done_d;
    end
  end

  assign o_Locked      = locked_q;
  assign o_Error       = error_q;
  assign o_Err_Count   = err_count_q;
  assign o_Lockup      = lockup_q;
  assign o_Period_Done = period_done_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed, table-driven bench for lfsr_checker (NUM_BITS=4). A second
// instance with a 2-bit error counter checks counter saturation.
module tb_lfsr_checker;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic        dv    = 1'b0;
  logic        clr   = 1'b0;
  logic [3:0]  data  = 4'h0;

  logic        locked, error, lockup, pd;
  logic [15:0] cnt;
  logic        s_locked, s_error, s_lockup, s_pd;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .NUM_BITS   (4),
    .LOCK_COUNT (3),
    .LOSS_COUNT (4),
    .CNT_BITS   (16)
  ) u_dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Enable      (en),
    .i_Data_DV     (dv),
    .i_Data        (data),
    .i_Clr_Count   (clr),
    .o_Locked      (locked),
    .o_Error       (error),
    .o_Err_Count   (cnt),
    .o_Lockup      (lockup),
    .o_Period_Done (pd)
  );

  lfsr_checker #(
    .NUM_BITS   (4),
    .LOCK_COUNT (3),
    .LOSS_COUNT (4),
    .CNT_BITS   (2)
  ) u_dut_sat (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Enable      (en),
    .i_Data_DV     (dv),
    .i_Data        (data),
    .i_Clr_Count   (clr),
    .o_Locked      (s_locked),
    .o_Error       (s_error),
    .o_Err_Count   (s_cnt),
    .o_Lockup      (s_lockup),
    .o_Period_Done (s_pd)
  );

  typedef struct {
    logic        en;
    logic        dv;
    logic [3:0]  data;
    logic        clr;
    logic        x_locked;
    logic        x_error;
    logic [15:0] x_cnt;
    logic        x_lockup;
    logic        x_pd;
  } vec_t;

  vec_t vq1[$];
  vec_t vq2[$];

  // Words following 0x7 in the N=4 XNOR sequence, up to the next 0x3.
  logic [3:0] seq_after7 [14] = '{4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2,
                                  4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h1, 4'h3};
  // Words following 0xC in the sequence, up to the next 0x3.
  logic [3:0] seq_after_c [9] = '{4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8,
                                  4'h0, 4'h1, 4'h3};

  function automatic vec_t mk(input logic e, input logic d, input logic [3:0] w,
                              input logic c, input logic xl, input logic xe,
                              input logic [15:0] xc, input logic xk, input logic xp);
    vec_t v;
    v.en = e; v.dv = d; v.data = w; v.clr = c;
    v.x_locked = xl; v.x_error = xe; v.x_cnt = xc; v.x_lockup = xk; v.x_pd = xp;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge take it, compare both DUTs.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [1:0] x_sat;
    en = v.en; dv = v.dv; data = v.data; clr = v.clr;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({locked, error, cnt, lockup, pd} !==
        {v.x_locked, v.x_error, v.x_cnt, v.x_lockup, v.x_pd}) begin
      n_bad++;
      $display("FAIL %s[%0d] got L=%0b E=%0b cnt=%0d K=%0b P=%0b want L=%0b E=%0b cnt=%0d K=%0b P=%0b",
               tag, idx, locked, error, cnt, lockup, pd,
               v.x_locked, v.x_error, v.x_cnt, v.x_lockup, v.x_pd);
    end
    x_sat = (v.x_cnt > 16'd3) ? 2'd3 : v.x_cnt[1:0];
    n_cmp++;
    if ({s_locked, s_error, s_cnt, s_lockup, s_pd} !==
        {v.x_locked, v.x_error, x_sat, v.x_lockup, v.x_pd}) begin
      n_bad++;
      $display("FAIL sat_%s[%0d] got L=%0b E=%0b cnt=%0d K=%0b P=%0b want L=%0b E=%0b cnt=%0d K=%0b P=%0b",
               tag, idx, s_locked, s_error, s_cnt, s_lockup, s_pd,
               v.x_locked, v.x_error, x_sat, v.x_lockup, v.x_pd);
    end
    $display("%s[%0d] en=%0b dv=%0b data=%h clr=%0b -> L=%0b E=%0b cnt=%0d K=%0b P=%0b",
             tag, idx, v.en, v.dv, v.data, v.clr, locked, error, cnt, lockup, pd);
  endtask

  // All outputs of both instances must be zero.
  task automatic check_zero(input string tag);
    n_cmp++;
    if ({locked, error, cnt, lockup, pd, s_locked, s_error, s_cnt, s_lockup, s_pd} !== '0) begin
      n_bad++;
      $display("FAIL %s got L=%0b E=%0b cnt=%0d K=%0b P=%0b (sat cnt=%0d) want all zero",
               tag, locked, error, cnt, lockup, pd, s_cnt);
    end
    $display("%s -> L=%0b E=%0b cnt=%0d K=%0b P=%0b", tag, locked, error, cnt, lockup, pd);
  endtask

  initial begin
    // ---------------- phase 1 vectors ----------------
    // Lock: seed 0x0, then three correct predictions.
    vq1.push_back(mk(1, 1, 4'h0, 0, 0, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h1, 0, 0, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h3, 0, 0, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h7, 0, 1, 0, 16'd0, 0, 0));
    // Clean run; 15th locked word (0x7) ends a period.
    for (int i = 0; i < 14; i++)
      vq1.push_back(mk(1, 1, seq_after7[i], 0, 1, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h7, 0, 1, 0, 16'd0, 0, 1));
    // Single error: 0x5 where 0xD is expected; prediction keeps running.
    vq1.push_back(mk(1, 1, 4'hE, 0, 1, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h5, 0, 1, 1, 16'd1, 0, 0));
    vq1.push_back(mk(1, 1, 4'hB, 0, 1, 0, 16'd1, 0, 0));
    // DV gap and enable-low gap carrying 0xF: neither is accepted.
    vq1.push_back(mk(1, 0, 4'hF, 0, 1, 0, 16'd1, 0, 0));
    vq1.push_back(mk(1, 1, 4'h6, 0, 1, 0, 16'd1, 0, 0));
    vq1.push_back(mk(0, 1, 4'hF, 0, 1, 0, 16'd1, 0, 0));
    vq1.push_back(mk(1, 1, 4'hC, 0, 1, 0, 16'd1, 0, 0));
    // Period still lands on the 15th accepted word despite the gaps.
    for (int i = 0; i < 9; i++)
      vq1.push_back(mk(1, 1, seq_after_c[i], 0, 1, 0, 16'd1, 0, 0));
    vq1.push_back(mk(1, 1, 4'h7, 0, 1, 0, 16'd1, 0, 1));
    // Loss: four consecutive wrong words, lock drops after the fourth.
    vq1.push_back(mk(1, 1, 4'h0, 0, 1, 1, 16'd2, 0, 0));
    vq1.push_back(mk(1, 1, 4'h0, 0, 1, 1, 16'd3, 0, 0));
    vq1.push_back(mk(1, 1, 4'h0, 0, 1, 1, 16'd4, 0, 0));
    vq1.push_back(mk(1, 1, 4'h0, 0, 0, 1, 16'd5, 0, 0));
    // Relock on seed + 3 matches; no error pulses while hunting.
    vq1.push_back(mk(1, 1, 4'h1, 0, 0, 0, 16'd5, 0, 0));
    vq1.push_back(mk(1, 1, 4'h3, 0, 0, 0, 16'd5, 0, 0));
    vq1.push_back(mk(1, 1, 4'h7, 0, 0, 0, 16'd5, 0, 0));
    vq1.push_back(mk(1, 1, 4'hE, 0, 1, 0, 16'd5, 0, 0));
    // Lockup word while locked (also a mismatch against 0xD), then held.
    vq1.push_back(mk(1, 1, 4'hF, 0, 1, 1, 16'd6, 1, 0));
    vq1.push_back(mk(1, 1, 4'hB, 0, 1, 0, 16'd6, 1, 0));
    // Clear alone, then clear coincident with an error (expected 0x6).
    vq1.push_back(mk(1, 0, 4'hB, 1, 1, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h0, 1, 1, 1, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'hC, 0, 1, 0, 16'd0, 0, 0));
    // Freeze with garbage data, then resume exactly on 0x9.
    vq1.push_back(mk(0, 1, 4'h0, 0, 1, 0, 16'd0, 0, 0));
    vq1.push_back(mk(0, 1, 4'h5, 0, 1, 0, 16'd0, 0, 0));
    vq1.push_back(mk(0, 0, 4'h3, 0, 1, 0, 16'd0, 0, 0));
    vq1.push_back(mk(1, 1, 4'h9, 0, 1, 0, 16'd0, 0, 0));

    // ---------------- phase 2 vectors (after mid-lock reset) ----------------
    // Lockup in HUNT, broken run re-seeds, lock only after 0x8.
    vq2.push_back(mk(1, 1, 4'hF, 0, 0, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'hA, 0, 0, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'h4, 0, 0, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'h5, 0, 0, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'hA, 0, 0, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'h4, 0, 0, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'h8, 0, 1, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 1, 4'h0, 0, 1, 0, 16'd0, 1, 0));
    vq2.push_back(mk(1, 0, 4'h0, 1, 1, 0, 16'd0, 0, 0));

    // ---------------- reset at start ----------------
    #2 rst_n = 1'b0;
    #1 check_zero("reset_init");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst_n = 1'b1;

    foreach (vq1[i]) apply(vq1[i], "p1", i);

    // ---------------- asynchronous reset while locked ----------------
    en = 1'b1; dv = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_mid_lock");
    @(posedge clk);
    #1;
    check_zero("reset_mid_held");
    rst_n = 1'b1;
    en = 1'b1; dv = 1'b0;
    @(posedge clk);
    #1;
    check_zero("after_reset_idle");

    foreach (vq2[i]) apply(vq2[i], "p2", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
